// File: rtl/led_pkg.sv
// Shared types, constants and rate-index arithmetic for the LED rate controller.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_REL
    } state_t;

    localparam int NUM_RATES = 9;

    // Button bit positions; a higher index wins arbitration.
    localparam logic [1:0] BTN_DN2 = 2'd3;
    localparam logic [1:0] BTN_DN1 = 2'd2;
    localparam logic [1:0] BTN_UP1 = 2'd1;
    localparam logic [1:0] BTN_UP2 = 2'd0;

    localparam logic signed [2:0] STEP_DN2 = -3'sd2;
    localparam logic signed [2:0] STEP_DN1 = -3'sd1;
    localparam logic signed [2:0] STEP_UP1 = 3'sd1;
    localparam logic signed [2:0] STEP_UP2 = 3'sd2;

    function automatic logic signed [2:0] step_of(input logic [1:0] sel);
        logic signed [2:0] s;
        s = STEP_UP2;
        case (sel)
            BTN_DN2: s = STEP_DN2;
            BTN_DN1: s = STEP_DN1;
            BTN_UP1: s = STEP_UP1;
            default: s = STEP_UP2;
        endcase
        return s;
    endfunction

    // Range of idx+step is -2..10, so one +/-9 correction always lands in 0..8.
    function automatic logic [3:0] next_idx(input logic [3:0] idx, input logic signed [2:0] step);
        logic signed [4:0] sum;
        sum = $signed({1'b0, idx}) + 5'(step);
        if (sum < 5'sd0) begin
            sum = sum + 5'(NUM_RATES);
        end else if (sum >= 5'(NUM_RATES)) begin
            sum = sum - 5'(NUM_RATES);
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability counter, debounced level and
// a one-cycle registered pulse on each debounced rising edge.
module btn_debounce
#(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            // Count consecutive samples that disagree with the accepted level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/led_rate_ctrl.sv
// Button-driven rate selector feeding the LED divider over valid/ready.
// Define AUTOREPEAT_EN to repeat the winning step while its button stays held.
module led_rate_ctrl
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int PERIOD_BASE     = 500000000,
    parameter int RESET_IDX       = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn,
    output logic [29:0] cfg_period,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [3:0]  rate_idx,
    output logic        busy
);

    localparam logic [31:0] BASE_32     = 32'(PERIOD_BASE);
    localparam logic [3:0]  RESET_IDX_4 = 4'(RESET_IDX);

    function automatic logic [29:0] period_of(input logic [3:0] idx);
        return 30'(BASE_32 >> idx);
    endfunction

    logic [3:0] w_level;
    logic [3:0] w_rise;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .i_btn  (btn[g]),
            .o_level(w_level[g]),
            .o_rise (w_rise[g])
        );
    end

    state_t      r_state, w_state_nx;
    logic [3:0]  r_idx, w_idx_nx;
    logic [29:0] r_period;
    logic        r_valid, w_valid_nx;
    logic        r_busy;
    logic        w_evt;
    logic [1:0]  w_win;

`ifdef AUTOREPEAT_EN
    localparam int REPEAT_CYCLES = 64 * DEBOUNCE_CYCLES;
    localparam int REP_W         = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

    logic [1:0]       r_win, w_win_nx;
    logic [REP_W-1:0] r_rep_cnt, w_rep_nx;
`endif

    // Same-cycle presses: highest button index wins, the rest are dropped.
    always_comb begin
        w_evt = |w_rise;
        w_win = BTN_UP2;
        if (w_rise[BTN_DN2]) begin
            w_win = BTN_DN2;
        end else if (w_rise[BTN_DN1]) begin
            w_win = BTN_DN1;
        end else if (w_rise[BTN_UP1]) begin
            w_win = BTN_UP1;
        end
    end

    // NOTE: every always_comb output is given a default first, so no latch is inferred.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_valid_nx = r_valid;
`ifdef AUTOREPEAT_EN
        w_win_nx   = r_win;
        w_rep_nx   = r_rep_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_evt) begin
                    w_idx_nx   = next_idx(r_idx, step_of(w_win));
                    w_valid_nx = 1'b1;
                    w_state_nx = LOAD;
`ifdef AUTOREPEAT_EN
                    w_win_nx   = w_win;
`endif
                end
            end
            LOAD: begin
                if (r_valid && cfg_ready) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = WAIT_REL;
`ifdef AUTOREPEAT_EN
                    w_rep_nx   = '0;
`endif
                end
            end
            WAIT_REL: begin
                if (w_level == 4'b0000) begin
                    w_state_nx = IDLE;
`ifdef AUTOREPEAT_EN
                end else if (w_level[r_win]) begin
                    if (r_rep_cnt == REP_MAX) begin
                        w_idx_nx   = next_idx(r_idx, step_of(r_win));
                        w_valid_nx = 1'b1;
                        w_state_nx = LOAD;
                    end else begin
                        w_rep_nx = r_rep_cnt + REP_W'(1);
                    end
                end else begin
                    w_rep_nx = '0;
`endif
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Reset lands in LOAD with cfg_valid high so the divider is reprogrammed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= LOAD;
            r_idx    <= RESET_IDX_4;
            r_period <= period_of(RESET_IDX_4);
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
`ifdef AUTOREPEAT_EN
            r_win     <= '0;
            r_rep_cnt <= '0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_idx    <= w_idx_nx;
            r_period <= period_of(w_idx_nx);
            r_valid  <= w_valid_nx;
            r_busy   <= (w_state_nx != IDLE);
`ifdef AUTOREPEAT_EN
            r_win     <= w_win_nx;
            r_rep_cnt <= w_rep_nx;
`endif
        end
    end

    assign cfg_period = r_period;
    assign cfg_valid  = r_valid;
    assign rate_idx   = r_idx;
    assign busy       = r_busy;

endmodule

// File: tb/tb_led_rate_ctrl.sv
// Directed bench for led_rate_ctrl with an arithmetic rate model checked every cycle.
module tb_led_rate_ctrl;

    localparam int DC = 4;
    localparam int PB = 512;
    localparam int RI = 0;
    localparam int NR = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn;
    logic [29:0] cfg_period;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  rate_idx;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, written only by the model process.
    int cyc     = 0;
    int m_idx   = 0;
    bit m_valid = 1'b0;

    // Requests from the stimulus, written only by the initial block.
    int due_cyc  = -1;
    int due_step = 0;
    bit m_chk    = 1'b0;

    always #5 clk = ~clk;

    led_rate_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .PERIOD_BASE    (PB),
        .RESET_IDX      (RI)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .cfg_period(cfg_period),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .rate_idx  (rate_idx),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_period(input int idx);
        return (PB >> idx) & 32'h3FFF_FFFF;
    endfunction

    // Model: reset loads RESET_IDX with a pending load; a scheduled step
    // moves the index modulo 9; a handshake retires the pending load.
    always @(posedge clk) begin
        if (reset) begin
            m_idx   = RI;
            m_valid = 1'b1;
        end else begin
            if (m_valid && cfg_ready) m_valid = 1'b0;
            if (cyc == due_cyc) begin
                m_idx   = (m_idx + due_step + NR) % NR;
                m_valid = 1'b1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_chk) begin
            check("cmp_rate_idx",   32'(rate_idx),   32'(m_idx));
            check("cmp_cfg_period", 32'(cfg_period), 32'(exp_period(m_idx)));
            check("cmp_cfg_valid",  32'(cfg_valid),  32'(m_valid));
        end
    end

    // Call at the negedge where the raw buttons become stable.
    task automatic expect_event(input int step, input int lit_idx, input int lit_period);
        due_step = step;
        due_cyc  = cyc + DC + 3;
        repeat (DC + 4) @(negedge clk);
        check("evt_idx",    32'(rate_idx),   32'(lit_idx));
        check("evt_period", 32'(cfg_period), 32'(lit_period));
        check("evt_valid",  32'(cfg_valid),  32'd1);
        check("evt_busy",   32'(busy),       32'd1);
    endtask

    task automatic handshake(input int hold_low);
        repeat (hold_low) @(negedge clk);
        check("pre_hs_valid", 32'(cfg_valid), 32'd1);
        cfg_ready = 1'b1;
        @(negedge clk);
        cfg_ready = 1'b0;
        check("hs_valid_drop", 32'(cfg_valid), 32'd0);
        check("hs_busy",       32'(busy),      32'd1);
    endtask

    task automatic release_all();
        btn = 4'b0000;
        repeat (DC + 5) @(negedge clk);
        check("rel_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        btn       = 4'b0000;
        cfg_ready = 1'b0;
        @(posedge clk);
        #1;
        m_chk = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state and the post-reset divider load.
        check("rst_valid",  32'(cfg_valid),  32'd1);
        check("rst_period", 32'(cfg_period), 32'd512);
        check("rst_idx",    32'(rate_idx),   32'd0);
        check("rst_busy",   32'(busy),       32'd1);
        handshake(0);
        release_all();

        // Ready while idle changes nothing.
        cfg_ready = 1'b1;
        repeat (3) @(negedge clk);
        cfg_ready = 1'b0;
        check("idle_ready_valid", 32'(cfg_valid), 32'd0);
        check("idle_ready_idx",   32'(rate_idx),  32'd0);

        // 0 with btn2 wraps to 8.
        btn[2] = 1'b1;
        expect_event(-1, 8, 2);
        handshake(0);
        release_all();

        // 8 with btn1 wraps to 0; valid holds while ready stays low.
        btn[1] = 1'b1;
        expect_event(1, 0, 512);
        handshake(5);
        release_all();

        // 0 with btn3 wraps to 7.
        btn[3] = 1'b1;
        expect_event(-2, 7, 4);
        handshake(0);
        release_all();

        // Bouncing btn0 gives a single event: 7 + 2 wraps to 0.
        for (int i = 0; i < 40; i++) begin
            btn[0] = (((i / 3) % 2) == 0);
            @(negedge clk);
        end
        btn[0] = 1'b1;
        expect_event(2, 0, 512);
        handshake(0);
        release_all();

        // Simultaneous btn3 and btn0 from 1: btn3 wins, btn0 is dropped.
        btn[1] = 1'b1;
        expect_event(1, 1, 256);
        handshake(0);
        release_all();
        btn = 4'b1001;
        expect_event(-2, 8, 2);
        handshake(0);
        release_all();
        check("arb_idx", 32'(rate_idx), 32'd8);

        // Presses during LOAD and WAIT_REL are ignored.
        btn[1] = 1'b1;
        expect_event(1, 0, 512);
        btn[2] = 1'b1;
        repeat (DC + 8) @(negedge clk);
        check("load_ign_idx",   32'(rate_idx),  32'd0);
        check("load_ign_valid", 32'(cfg_valid), 32'd1);
        handshake(0);
        btn[2] = 1'b0;
        repeat (DC + 6) @(negedge clk);
        btn[2] = 1'b1;
        repeat (DC + 8) @(negedge clk);
        check("wrel_ign_idx",  32'(rate_idx), 32'd0);
        check("wrel_ign_busy", 32'(busy),     32'd1);
        release_all();

        // Reset in the middle of LOAD restores the reset rate and reloads it.
        btn[0] = 1'b1;
        expect_event(2, 2, 128);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_idx",    32'(rate_idx),   32'd0);
        check("mid_rst_period", 32'(cfg_period), 32'd512);
        check("mid_rst_valid",  32'(cfg_valid),  32'd1);
        check("mid_rst_busy",   32'(busy),       32'd1);
        handshake(0);
        release_all();

`ifdef AUTOREPEAT_EN
        // Holding btn1 from 0 with ready high: one press plus three repeats.
        m_chk     = 1'b0;
        cfg_ready = 1'b1;
        btn[1]    = 1'b1;
        for (int t = 0; t < 4 * (64 * DC + 16) + 4 * DC && rate_idx != 4'd4; t++) begin
            @(negedge clk);
        end
        btn = 4'b0000;
        repeat (DC + 5) @(negedge clk);
        cfg_ready = 1'b0;
        check("rep_idx",    32'(rate_idx),   32'd4);
        check("rep_period", 32'(cfg_period), 32'd32);
        check("rep_busy",   32'(busy),       32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
